// File: rtl/pulse_meter.sv
// pulse_meter
//   Measures each full period of a single-bit pulse train in clk cycles.
//   Reports the high time, the low time and the total period once per
//   completed period, at the rising edge that closes it. The partial period
//   seen after enabling is never reported.
//
// Configuration macro: PULSE_METER_SYNC_EN
//   Defined   : two-flop synchronizer in front of the input stage, for an
//               'in' that is asynchronous to clk (adds 2 cycles of latency,
//               widths unchanged).
//   Undefined : 'in' must be synchronous to clk; no synchronizer is built.
//
// Ports
//   clk        in   1             system clock
//   nrst       in   1             synchronous active-low reset
//   ena        in   1             measurement enable; 0 forces IDLE
//   in         in   1             pulse train under measurement
//   high_width out  CNTR_WIDTH    cycles 'in' was high in last completed period
//   low_width  out  CNTR_WIDTH    cycles 'in' was low in last completed period
//   period     out  CNTR_WIDTH+1  high_width + low_width, full precision
//   overflow   out  1             a counter saturated during last reported period
//   meas_valid out  1             1-cycle strobe: results updated this cycle
//   busy       out  1             state != IDLE
module pulse_meter #(
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ena,
  input  logic                  in,
  output logic [CNTR_WIDTH-1:0] high_width,
  output logic [CNTR_WIDTH-1:0] low_width,
  output logic [CNTR_WIDTH:0]   period,
  output logic                  overflow,
  output logic                  meas_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  function automatic logic [CNTR_WIDTH-1:0] sat_inc(input logic [CNTR_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                  in_src;
  logic                  in_d_q, in_prev_q;
  state_t                state_q, state_d;
  logic [CNTR_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic                  ovf_q, ovf_d;
  logic [CNTR_WIDTH-1:0] high_width_q, high_width_d, low_width_q, low_width_d;
  logic [CNTR_WIDTH:0]   period_q, period_d;
  logic                  overflow_q, overflow_d;
  logic                  meas_valid_q, meas_valid_d;
  logic                  rise, fall;

`ifdef PULSE_METER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign in_src = sync2_q;
`else
  assign in_src = in;
`endif

  assign rise = in_d_q & ~in_prev_q;
  assign fall = ~in_d_q & in_prev_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    ovf_d        = ovf_q;
    high_width_d = high_width_q;
    low_width_d  = low_width_q;
    period_d     = period_q;
    overflow_d   = overflow_q;
    meas_valid_d = 1'b0;

    if (!ena) begin
      // Abort: the running period is dropped, reported results hold.
      state_d = IDLE;
      hi_d    = '0;
      lo_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (rise) begin
            state_d = HIGH;
            hi_d    = CNT_ONE;
            lo_d    = '0;
            ovf_d   = 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lo_d    = CNT_ONE;
          end else if (in_d_q) begin
            hi_d = sat_inc(hi_q);
            if (hi_q == CNT_MAX) ovf_d = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            // The rise closing this period also opens the next one.
            high_width_d = hi_q;
            low_width_d  = lo_q;
            period_d     = {1'b0, hi_q} + {1'b0, lo_q};
            overflow_d   = ovf_q;
            meas_valid_d = 1'b1;
            state_d      = HIGH;
            hi_d         = CNT_ONE;
            lo_d         = '0;
            ovf_d        = 1'b0;
          end else if (!in_d_q) begin
            lo_d = sat_inc(lo_q);
            if (lo_q == CNT_MAX) ovf_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      in_d_q       <= 1'b0;
      in_prev_q    <= 1'b0;
      state_q      <= IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      ovf_q        <= 1'b0;
      high_width_q <= '0;
      low_width_q  <= '0;
      period_q     <= '0;
      overflow_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      in_d_q       <= in_src;
      in_prev_q    <= in_d_q;
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      ovf_q        <= ovf_d;
      high_width_q <= high_width_d;
      low_width_q  <= low_width_d;
      period_q     <= period_d;
      overflow_q   <= overflow_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign high_width = high_width_q;
  assign low_width  = low_width_q;
  assign period     = period_q;
  assign overflow   = overflow_q;
  assign meas_valid = meas_valid_q;
  assign busy       = (state_q != IDLE);

endmodule
